// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared UART defaults, bit-timing helpers and receiver state encoding.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int c_CLK_HZ_DEF = 10_000_000;
    localparam int c_BAUD_DEF   = 115_200;

    // Rounded clocks-per-bit so that odd ratios land on the nearest cycle.
    function automatic int uart_bit_cyc(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int uart_half(input int clk_hz, input int baud);
        return uart_bit_cyc(clk_hz, baud) / 2;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// Module : sync_2ff
// Brief  : 1-bit two-flop synchronizer with a parameterized reset value.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sys_clk_i,
    input  logic sys_rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module : uart_rx
// Brief  : 8N1 UART receiver with a single holding register and error flags.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = c_CLK_HZ_DEF,
    parameter int BAUD   = c_BAUD_DEF
) (
    input  logic       sys_clk_i,
    input  logic       sys_rstn_i,
    input  logic       uart_rx_i,
    input  logic       rx_rd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_frame_err_o,
    output logic       rx_overrun_o
);

    localparam int c_BIT_CYC = uart_bit_cyc(CLK_HZ, BAUD);
    localparam int c_HALF    = uart_half(CLK_HZ, BAUD);
    localparam int c_CNT_W   = (c_BIT_CYC > 1) ? $clog2(c_BIT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_BIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);

    logic               w_rxs;
    rx_state_e          r_state,   w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_shift,   w_shift_nxt;
    logic               w_deliver;
    logic               w_frame_err;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .sys_clk_i  (sys_clk_i),
        .sys_rstn_i (sys_rstn_i),
        .d_i        (uart_rx_i),
        .q_o        (w_rxs)
    );

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // The counter restarts at every sample point, so timing re-anchors per bit.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_deliver     = 1'b0;
        w_frame_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {w_rxs, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                w_cnt_nxt = '0;
                if (w_rxs) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A read in the delivery cycle frees the slot, so the new byte is taken.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            if (w_deliver) begin
                if (!r_valid || rx_rd_i) begin
                    r_data    <= r_shift;
                    r_valid   <= 1'b1;
                    r_overrun <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (rx_rd_i && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data_o      = r_data;
    assign rx_valid_o     = r_valid;
    assign rx_frame_err_o = r_frame_err;
    assign rx_overrun_o   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module : tb_uart_rx
// Brief  : Self-checking bench for uart_rx: vector table, corner sequences, random frames.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

    localparam int c_CLK_HZ = 10_000_000;
    localparam int c_BAUD   = 115_200;
    localparam int c_BIT    = (c_CLK_HZ + c_BAUD / 2) / c_BAUD;
    localparam int c_HALF   = c_BIT / 2;
    localparam int c_LAT    = 2 + c_HALF + 9 * c_BIT + 1;

    logic       sys_clk_i = 1'b0;
    logic       sys_rstn_i;
    logic       uart_rx_i;
    logic       rx_rd_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_frame_err_o;
    logic       rx_overrun_o;

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;

    uart_rx #(
        .CLK_HZ (c_CLK_HZ),
        .BAUD   (c_BAUD)
    ) dut (
        .sys_clk_i      (sys_clk_i),
        .sys_rstn_i     (sys_rstn_i),
        .uart_rx_i      (uart_rx_i),
        .rx_rd_i        (rx_rd_i),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_frame_err_o (rx_frame_err_o),
        .rx_overrun_o   (rx_overrun_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    always @(negedge sys_clk_i) begin
        if (rx_frame_err_o) fe_cnt <= fe_cnt + 1;
    end

    typedef struct {
        logic [7:0] din;
        logic       stop_ok;
        logic       rd_first;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_over;
        int         exp_fe;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk_i);
            #1;
        end
    endtask

    function automatic logic line_at(input logic [7:0] b, input logic stop_ok, input int off);
        int idx;
        idx = off / c_BIT;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return stop_ok;
    endfunction

    // Drives one frame; rd_at selects a cycle offset to assert rx_rd_i (-1 = none).
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int stop_len,
                              input int rd_at, output int first_valid_off);
        logic prev_valid;
        prev_valid      = rx_valid_o;
        first_valid_off = -1;
        for (int off = 0; off < 9 * c_BIT + stop_len; off++) begin
            if (first_valid_off < 0 && rx_valid_o && !prev_valid) first_valid_off = off;
            prev_valid = rx_valid_o;
            uart_rx_i  = (off < 9 * c_BIT) ? line_at(b, stop_ok, off) : stop_ok;
            rx_rd_i    = (off == rd_at);
            tick();
        end
        uart_rx_i = 1'b1;
        rx_rd_i   = 1'b0;
        tick(2);
    endtask

    task automatic pulse_rd();
        rx_rd_i = 1'b1;
        tick();
        rx_rd_i = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input int d, input int v, input int o);
        chk({tag, "_data"}, rx_data_o, d);
        chk({tag, "_valid"}, rx_valid_o, v);
        chk({tag, "_over"}, rx_overrun_o, o);
    endtask

    initial begin
        int fv;
        int fe0;
        logic [7:0] m_data;
        logic       m_valid;
        logic       m_over;

        vecs[0] = '{8'hA3, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 0};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 0};
        vecs[3] = '{8'h7E, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1};
        vecs[4] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 0};
        vecs[7] = '{8'h01, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 0};

        sys_rstn_i = 1'b1;
        uart_rx_i  = 1'b1;
        rx_rd_i    = 1'b0;
        #3 sys_rstn_i = 1'b0;
        tick(4);
        chk_outs("reset", 0, 0, 0);
        chk("reset_ferr", rx_frame_err_o, 0);
        sys_rstn_i = 1'b1;
        tick(5);

        // Exact delivery latency on 0x55
        send_frame(8'h55, 1'b1, c_BIT, -1, fv);
        chk("lat55_cycle", fv, c_LAT);
        chk_outs("lat55", 8'h55, 1, 0);
        chk("lat55_ferr", fe_cnt, 0);
        pulse_rd();
        chk_outs("rd55", 8'h55, 0, 0);

        // Long low stop bit: one error pulse, no restart until the line rises
        fe0 = fe_cnt;
        send_frame(8'h7E, 1'b0, 300, -1, fv);
        tick(1000);
        chk("brk_fe_pulses", fe_cnt - fe0, 1);
        chk_outs("brk", 8'h55, 0, 0);
        send_frame(8'h12, 1'b1, c_BIT, -1, fv);
        chk_outs("after_brk", 8'h12, 1, 0);
        pulse_rd();

        // Short low glitch on an idle line
        fe0 = fe_cnt;
        uart_rx_i = 1'b0;
        tick(20);
        uart_rx_i = 1'b1;
        tick(1000);
        chk("glitch_valid", rx_valid_o, 0);
        chk("glitch_fe", fe_cnt - fe0, 0);

        // Read in the exact delivery cycle of the next byte
        send_frame(8'h11, 1'b1, c_BIT, -1, fv);
        chk_outs("hold11", 8'h11, 1, 0);
        send_frame(8'h22, 1'b1, c_BIT, c_LAT - 1, fv);
        chk_outs("same_cyc", 8'h22, 1, 0);
        pulse_rd();
        chk_outs("rd22", 8'h22, 0, 0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rd_first) pulse_rd();
            tick(3);
            fe0 = fe_cnt;
            send_frame(vecs[i].din, vecs[i].stop_ok, c_BIT, -1, fv);
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_over);
            chk($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
        end
        pulse_rd();
        chk_outs("rd_clear", 8'h80, 0, 0);

        // Reset in the middle of bit 4 of 0xFF
        send_frame(8'h99, 1'b1, c_BIT, -1, fv);
        for (int off = 0; off < 5 * c_BIT + 30; off++) begin
            uart_rx_i = line_at(8'hFF, 1'b1, off);
            tick();
        end
        #2 sys_rstn_i = 1'b0;
        #1;
        chk_outs("midrst", 0, 0, 0);
        chk("midrst_ferr", rx_frame_err_o, 0);
        uart_rx_i = 1'b1;
        tick(5);
        sys_rstn_i = 1'b1;
        tick(5);
        send_frame(8'h3C, 1'b1, c_BIT, -1, fv);
        chk_outs("post_rst", 8'h3C, 1, 0);
        pulse_rd();

        // Random frames against a byte-level model of the holding register
        m_data  = 8'h3C;
        m_valid = 1'b0;
        m_over  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            logic       ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                pulse_rd();
                if (m_valid) begin
                    m_valid = 1'b0;
                    m_over  = 1'b0;
                end
            end
            tick($urandom_range(0, 15));
            fe0 = fe_cnt;
            send_frame(b, ok, c_BIT, -1, fv);
            if (ok) begin
                if (m_valid) m_over = 1'b1;
                else begin
                    m_data  = b;
                    m_valid = 1'b1;
                end
            end
            chk_outs($sformatf("rnd%0d", i), m_data, m_valid, m_over);
            chk($sformatf("rnd%0d_fe", i), fe_cnt - fe0, ok ? 0 : 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have port sys_clk_i, input, 1, system clock.
REQ-004 SHALL have port sys_rstn_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port uart_rx_i, input, 1, asynchronous serial line; idle high.
REQ-006 SHALL have port rx_rd_i, input, 1, consumer acknowledge; pops the held byte.
REQ-007 SHALL have port rx_data_o, output, 8, last received byte.
REQ-008 SHALL have port rx_valid_o, output, 1, high while rx_data_o holds an unread byte.
REQ-009 SHALL have port rx_frame_err_o, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port rx_overrun_o, output, 1, sticky; a byte was lost while rx_valid_o was high.

Function
REQ-011 SHALL pass uart_rx_i through a 2-flop synchronizer; all logic uses the synchronized line (rxs).
REQ-012 SHALL use BIT_CYC = (CLK_HZ + BAUD/2) / BAUD and HALF = BIT_CYC/2, integer constants; at defaults these are 87 and 43.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP and WAIT_HIGH, with a cycle counter sized for BIT_CYC-1 and a 3-bit bit index.
REQ-014 IDLE: on the first cycle rxs==0 -> START, counter cleared; that cycle is T0.
REQ-015 START: sample rxs at T0+HALF; if 0 -> DATA; if 1 -> IDLE (glitch rejected, no outputs change).
REQ-016 DATA: sample at T0+HALF+k*BIT_CYC for k=1..8; bits are LSB first into an 8-bit shifter; after k=8 -> STOP.
REQ-017 STOP: sample at T0+HALF+9*BIT_CYC; if rxs==1 -> deliver the byte and go to IDLE.
REQ-018 STOP with rxs==0: pulse rx_frame_err_o for exactly one cycle, discard the byte, then WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rxs==1, then -> IDLE; this covers break conditions.
REQ-020 Delivery: on the cycle after the stop sample, rx_data_o SHALL take the byte and rx_valid_o SHALL be 1.
REQ-021 rx_rd_i while rx_valid_o==1: rx_valid_o and rx_overrun_o SHALL clear next cycle; rx_data_o is unchanged.
REQ-022 rx_rd_i while rx_valid_o==0 SHALL be ignored.
REQ-023 Delivery while rx_valid_o==1 and rx_rd_i==0: the new byte SHALL be dropped, rx_data_o kept, and rx_overrun_o set.
REQ-024 Delivery in the same cycle as rx_rd_i with rx_valid_o==1: the new byte SHALL be loaded, rx_valid_o stays 1, and no overrun.
REQ-025 The receiver SHALL resynchronize on every start bit; there is no accumulated drift across bytes.

Reset
REQ-026 Reset asserted SHALL immediately give: FSM=IDLE, counters 0, shifter 0, rx_data_o=0x00, rx_valid_o=0, rx_frame_err_o=0, rx_overrun_o=0, synchronizer flops=1.
REQ-027 Reset mid-frame SHALL abandon the frame; after release a new start is detected only after rxs has been observed low from IDLE.

Structure
REQ-028 Package uart_pkg SHALL hold the CLK_HZ/BAUD defaults, the BIT_CYC/HALF computation and the FSM state encoding, shared with the transmitter.
REQ-029 The synchronizer SHALL be sub-module sync_2ff (1-bit, async reset value parameterized, here 1).
REQ-030 Expected RTL size is 120-250 lines; no FIFO is included (single holding register).

Verification
REQ-031 Send 0x55, 1 stop bit -> rx_valid_o=1 and rx_data_o=0x55 at T0+43+9*87+1 (+2 sync), with no error flags.
REQ-032 Send 0xA3 then 0x00 back-to-back with no rx_rd_i -> rx_data_o=0xA3 and rx_overrun_o=1; after rx_rd_i both flags are 0.
REQ-033 Send 0x7E with the stop bit driven low for 300 cycles -> a single rx_frame_err_o pulse, rx_valid_o=0, no new start until the line goes high; then 0x12 is received correctly.
REQ-034 A 20-cycle low glitch on an idle line -> FSM returns to IDLE and no rx_valid_o.
REQ-035 Assert reset during bit 4 of 0xFF, release, then send 0x3C -> all outputs 0 during reset, then rx_data_o=0x3C.
REQ-036 Hold 0x11 unread, then pulse rx_rd_i in exactly the delivery cycle of 0x22 -> rx_data_o=0x22, rx_valid_o=1, rx_overrun_o=0.
